// File: rtl/weights_mem_mc.sv
// Multi-channel 16-bit write / 32- or 64-bit read front end for a single-port 64-bit weights SRAM.
// Writes park in per-channel holding registers and drain round-robin, merging same-row lanes.
module weights_mem_mc #(
  parameter  int NUM_WR     = 2,
  parameter  int ROWS       = 2048,
  parameter  int RD_W       = 32,
  parameter  int STARVE_MAX = 4,
  localparam int RW         = $clog2(ROWS),
  localparam int WA_W       = RW + 2,
  localparam int RA_W       = RW + ((RD_W == 32) ? 1 : 0)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_WR-1:0]      wr_valid,
  output logic [NUM_WR-1:0]      wr_ready,
  input  logic [NUM_WR*WA_W-1:0] wr_addr,
  input  logic [NUM_WR*16-1:0]   wr_data,
  input  logic                   rd_req,
  output logic                   rd_ready,
  input  logic [RA_W-1:0]        rd_addr,
  output logic [RD_W-1:0]        rd_data,
  output logic                   rd_valid,
  output logic                   mem_men,
  output logic                   mem_wen,
  output logic                   mem_ren,
  output logic [RW-1:0]          mem_addr,
  output logic [63:0]            mem_din,
  output logic [63:0]            mem_bm,
  input  logic [63:0]            mem_dout
);

  localparam int PW = (NUM_WR < 2) ? 1 : $clog2(NUM_WR);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [NUM_WR-1:0] held_q;
  logic [RW-1:0]     hrow_q  [NUM_WR];
  logic [1:0]        hlane_q [NUM_WR];
  logic [15:0]       hdata_q [NUM_WR];
  logic [PW-1:0]     rr_q, rr_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rd_pend_q, rd_half_q, rd_valid_q;
  logic [RD_W-1:0]   rd_data_q, rd_data_d;

  logic              any_held, do_read, do_write, rd_half, found;
  logic [RW-1:0]     rd_row;
  logic [PW-1:0]     gnt, cand;
  logic [NUM_WR-1:0] drained, wr_acc;
  logic [3:0]        lane_mask;
  logic [63:0]       wr_din, wr_bm, dout_sh;

  // Reads win unless a held write has already been passed over STARVE_MAX times.
  // rst gates the read so the macro pins stay quiet while reset is asserted.
  assign any_held = |held_q;
  assign rd_ready = !(any_held && (starve_q == SW'(STARVE_MAX)));
  assign do_read  = rst & rd_req & rd_ready;
  assign do_write = !do_read & any_held;
  assign rd_row   = RW'(rd_addr >> (RA_W - RW));
  assign rd_half  = (RD_W == 32) ? rd_addr[0] : 1'b0;
  assign wr_ready = ~held_q | drained;
  assign wr_acc   = wr_valid & wr_ready;

  // NOTE: every variable of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      cand = PW'((int'(rr_q) + k) % NUM_WR);
      if (!found && held_q[cand]) begin
        gnt   = cand;
        found = 1'b1;
      end
    end
  end

  // The granted channel always drains; others join only on the same row with a still-free lane.
  always_comb begin
    drained   = '0;
    lane_mask = '0;
    wr_din    = '0;
    wr_bm     = '0;
    if (do_write) begin
      drained[gnt]                          = 1'b1;
      lane_mask[hlane_q[gnt]]               = 1'b1;
      wr_din[{hlane_q[gnt], 4'b0000} +: 16] = hdata_q[gnt];
      wr_bm[{hlane_q[gnt], 4'b0000} +: 16]  = 16'hFFFF;
      for (int i = 0; i < NUM_WR; i++) begin
        if ((PW'(i) != gnt) && held_q[i] && (hrow_q[i] == hrow_q[gnt]) &&
            !lane_mask[hlane_q[i]]) begin
          drained[i]                          = 1'b1;
          lane_mask[hlane_q[i]]               = 1'b1;
          wr_din[{hlane_q[i], 4'b0000} +: 16] = hdata_q[i];
          wr_bm[{hlane_q[i], 4'b0000} +: 16]  = 16'hFFFF;
        end
      end
    end
  end

  always_comb begin
    rr_d     = rr_q;
    starve_d = starve_q;
    if (do_write) begin
      rr_d     = (int'(gnt) == NUM_WR - 1) ? '0 : gnt + 1'b1;
      starve_d = '0;
    end else if (do_read && any_held && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    dout_sh   = rd_half_q ? {32'h0, mem_dout[63:32]} : mem_dout;
    rd_data_d = dout_sh[RD_W-1:0];
  end

  assign mem_ren  = do_read;
  assign mem_wen  = do_write;
  assign mem_men  = do_read | do_write;
  assign mem_addr = do_read ? rd_row : (do_write ? hrow_q[gnt] : '0);
  assign mem_din  = wr_din;
  assign mem_bm   = wr_bm;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_q     <= '0;
      rr_q       <= '0;
      starve_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_half_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_acc[i])       held_q[i] <= 1'b1;
        else if (drained[i]) held_q[i] <= 1'b0;
      end
      rr_q       <= rr_d;
      starve_q   <= starve_d;
      rd_pend_q  <= do_read;
      rd_half_q  <= rd_half;
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) rd_data_q <= rd_data_d;
    end
  end

  // NOTE: holding-register payloads are not reset; held_q alone says whether an entry is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_acc[i]) begin
        hrow_q[i]  <= wr_addr[i*WA_W+2 +: RW];
        hlane_q[i] <= wr_addr[i*WA_W +: 2];
        hdata_q[i] <= wr_data[i*16 +: 16];
      end
    end
  end

endmodule

// File: doc/weights_mem_mc.md
WEIGHTS_MEM_MC -- requirements
Module: weights_mem_mc

Interface
REQ-001 The block SHALL expose parameter NUM_WR, default 2, number of 16-bit write channels (legal 1..4).
REQ-002 The block SHALL expose parameter ROWS, default 2048, macro depth in 64-bit rows (power of 2).
REQ-003 The block SHALL expose parameter RD_W, default 32, read width (legal 32 or 64).
REQ-004 The block SHALL expose parameter STARVE_MAX, default 4, max consecutive reads while a write is pending.
REQ-005 Derived widths SHALL be RW=log2(ROWS), WA_W=RW+2, RA_W=RW+(RD_W==32 ? 1 : 0).
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 wr_valid  in  NUM_WR  per-channel write request.
REQ-009 wr_ready  out  NUM_WR  per-channel write accept.
REQ-010 wr_addr  in  NUM_WR*WA_W  16-bit element address: row=[WA_W-1:2], lane=[1:0].
REQ-011 wr_data  in  NUM_WR*16  write data.
REQ-012 rd_req / rd_ready / rd_addr  in / out / in RA_W  read handshake; for RD_W=32, row=rd_addr[RA_W-1:1], half=rd_addr[0].
REQ-013 rd_data  out  RD_W;  rd_valid  out  1  registered read result.
REQ-014 mem_men, mem_wen, mem_ren  out  1 each;  mem_addr  out  RW;  mem_din, mem_bm  out  64;  mem_dout  in  64  single-port SRAM macro pins, 1-cycle read latency.

Function
REQ-015 A write SHALL be accepted when wr_valid[i]&wr_ready[i] and stored in channel i's one-entry holding register.
REQ-016 wr_ready[i] SHALL be !held[i] | drained[i] (drained = entry written to macro this cycle).
REQ-017 Lane L SHALL occupy mem_din/mem_bm bits [16L+15:16L]; mem_bm SHALL be 16'hFFFF per written lane, 0 elsewhere.
REQ-018 Each cycle the block SHALL issue exactly one of IDLE, READ, WRITE to the macro; mem_men=mem_ren|mem_wen.
REQ-019 READ SHALL be chosen when rd_req&rd_ready; rd_ready SHALL be 0 only when any held and starve_cnt==STARVE_MAX.
REQ-020 WRITE SHALL be chosen when no READ is issued and any entry is held.
REQ-021 starve_cnt SHALL increment on a READ cycle with any entry held, clear on WRITE cycle, saturate at STARVE_MAX.
REQ-022 WRITE grant SHALL go round-robin to the first held channel at or after pointer rr; rr SHALL become grant+1 mod NUM_WR.
REQ-023 In the same WRITE, every other held channel with the same row and a lane distinct from all already-merged lanes SHALL be merged (ascending index order) and drained.
REQ-024 Same row, same lane collision: only the earlier-merged channel drains; the other stays held.
REQ-025 Read accepted at cycle T: macro access at T, rd_data/rd_valid at T+2, rd_valid a one-cycle pulse per read; back-to-back reads SHALL stream one per cycle.
REQ-026 RD_W=32: rd_data SHALL be mem_dout[63:32] when captured half=1, else [31:0]; RD_W=64: full row.
REQ-027 A read in the same cycle a matching write is held SHALL return pre-write data (no forwarding).
REQ-028 rd_data SHALL hold its last value while rd_valid=0.
REQ-029 When idle, mem_addr, mem_din, mem_bm SHALL be 0.

Reset
REQ-030 While rst=0: held all 0, rr=0, starve_cnt=0, rd_valid=0, rd_data=0, mem_* outputs 0, wr_ready all 1, rd_ready 1.
REQ-031 Reset mid-operation SHALL discard held writes and in-flight reads; no rd_valid SHALL follow from pre-reset reads.

Verification
REQ-032 Ch0 writes 0xAAAA @ addr 0x0010, ch1 0xBBBB @ 0x0013 same cycle -> single WRITE, mem_addr=4, mem_bm=0xFFFF00000000FFFF; then read rd_addr=9 (row 4, half 1) -> rd_data=0xBBBB0000 two cycles later.
REQ-033 Ch0 and ch1 both write lane 0 row 7 same cycle -> two WRITE cycles, ch0 first (rr=0), final read of row 7 half 0 low 16 bits = ch1 data.
REQ-034 rd_req held high continuously with one write held, STARVE_MAX=4 -> 4 READs, rd_ready=0 one cycle, WRITE, reads resume; rd_valid pulses match accepted count.
REQ-035 Streaming 8 reads rows 0..7 -> 8 consecutive rd_valid pulses starting 2 cycles after first accept, in order.
REQ-036 Assert rst=0 asynchronously with a write held and a read at T+1 -> outputs 0 immediately, no rd_valid after release, subsequent read shows no write.
REQ-037 RD_W=64, NUM_WR=4, four writes to lanes 0..3 of row 3 -> one WRITE with mem_bm=all ones, read returns concatenated data.
